// File: rtl/matrix_accel_pkg.sv
// Shared types and constants for the matrix accelerator sequencer and its datapath.
package matrix_accel_pkg;

  localparam int unsigned KERNEL_SIZE_DEF = 3;
  localparam int unsigned KK              = KERNEL_SIZE_DEF * KERNEL_SIZE_DEF;
  localparam int unsigned REST_ADDR       = KERNEL_SIZE_DEF ** 4;
  localparam int unsigned START_GUARD     = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    CAPTURE,
    EMIT,
    FINISH
  } seq_state_e;

endpackage

// File: rtl/matrix_seq_addr_gen.sv
// Crossbar AddressSelect generator: (base + pass index) wrapped into the REST_ADDR space.
module matrix_seq_addr_gen #(
  parameter int unsigned REST_ADDR  = matrix_accel_pkg::REST_ADDR,
  parameter int unsigned ADDR_WIDTH = $clog2(REST_ADDR),
  parameter int unsigned PASS_W     = 8
) (
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [PASS_W-1:0]     pass_idx,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam int unsigned SUM_W = ((ADDR_WIDTH > PASS_W) ? ADDR_WIDTH : PASS_W) + 1;

  logic [SUM_W-1:0] sum;

  always_comb begin
    sum  = SUM_W'(base) + SUM_W'(pass_idx);
    addr = ADDR_WIDTH'(sum % SUM_W'(REST_ADDR));
  end

endmodule

// File: rtl/matrix_accel_sequencer.sv
// Multi-pass job sequencer for one matrixAccelerator instance.
// Optional performance counters are enabled with MATRIX_SEQ_PERF_EN.
module matrix_accel_sequencer
  import matrix_accel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned KERNEL_SIZE    = KERNEL_SIZE_DEF,
  parameter int unsigned REST_ADDR      = KERNEL_SIZE ** 4,
  parameter int unsigned ADDR_WIDTH     = $clog2(REST_ADDR),
  parameter int unsigned PASS_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                   Clk,
  input  logic                                   Rst,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [PASS_W-1:0]                      cmd_passes,
  input  logic [ADDR_WIDTH-1:0]                  cmd_addr_base,
  input  logic                                   cmd_direct,
  input  logic                                   cmd_accumulate,
  input  logic                                   op_valid,
  output logic                                   op_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]     mStart,
  output logic [ADDR_WIDTH-1:0]                  AddressSelect,
  output logic                                   direct,
  input  logic                                   finalReady,
  input  logic signed [DATA_WIDTH-1:0]           finalAccumulate,
  output logic                                   res_valid,
  input  logic                                   res_ready,
  output logic signed [DATA_WIDTH-1:0]           res_data,
  output logic                                   res_last,
  output logic                                   busy,
  output logic                                   done,
`ifdef MATRIX_SEQ_PERF_EN
  output logic                                   timeout_err,
  output logic [31:0]                            perf_busy_cycles,
  output logic [31:0]                            perf_stall_cycles
`else
  output logic                                   timeout_err
`endif
);

  localparam int unsigned NUM_MUL = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW      = 2;

  seq_state_e                    state_q, state_d;
  logic [PASS_W-1:0]             passes_q, passes_d;
  logic [PASS_W-1:0]             pass_idx_q, pass_idx_d;
  logic [ADDR_WIDTH-1:0]         base_q, base_d;
  logic [ADDR_WIDTH-1:0]         addr_sel_q, addr_sel_d;
  logic [ADDR_WIDTH-1:0]         addr_nxt;
  logic                          accum_q, accum_d;
  logic                          direct_q, direct_d;
  logic signed [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]  res_data_q, res_data_d;
  logic signed [DATA_WIDTH-1:0]  acc_sum;
  logic                          res_last_q, res_last_d;
  logic [GW-1:0]                 guard_q, guard_d;
  logic [TW-1:0]                 tmo_q, tmo_d;
  logic                          timeout_err_q, timeout_err_d;
  logic                          cmd_ready_q, op_ready_q, res_valid_q, busy_q, done_q;
  logic [NUM_MUL-1:0]            mstart_q;
  logic                          last_pass;
  logic                          cmd_fire;

  assign last_pass = (pass_idx_q == passes_q - 1'b1);
  assign cmd_fire  = cmd_valid && cmd_ready_q;
  assign acc_sum   = acc_q + finalAccumulate;

  // Address is computed from the next-cycle base/index so it is valid on LOAD entry.
  matrix_seq_addr_gen #(
    .REST_ADDR  (REST_ADDR),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PASS_W     (PASS_W)
  ) u_addr_gen (
    .base     (base_d),
    .pass_idx (pass_idx_d),
    .addr     (addr_nxt)
  );

  always_comb begin
    state_d       = state_q;
    passes_d      = passes_q;
    pass_idx_d    = pass_idx_q;
    base_d        = base_q;
    accum_d       = accum_q;
    direct_d      = direct_q;
    acc_d         = acc_q;
    res_data_d    = res_data_q;
    res_last_d    = res_last_q;
    guard_d       = guard_q;
    tmo_d         = tmo_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          passes_d      = cmd_passes;
          base_d        = cmd_addr_base;
          direct_d      = cmd_direct;
          accum_d       = cmd_accumulate;
          pass_idx_d    = '0;
          acc_d         = '0;
          timeout_err_d = 1'b0;
          state_d       = (cmd_passes == '0) ? FINISH : LOAD;
        end
      end
      LOAD: begin
        if (op_valid && op_ready_q) begin
          guard_d = GW'(START_GUARD);
          tmo_d   = '0;
          state_d = START;
        end
      end
      START: begin
        guard_d = guard_q - 1'b1;
        tmo_d   = tmo_q + 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // finalReady lags the multipliers by a register, so the first cycles may be stale.
        if (guard_q != '0) guard_d = guard_q - 1'b1;
        tmo_d = tmo_q + 1'b1;
        if (guard_q == '0 && finalReady) begin
          state_d = CAPTURE;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = FINISH;
        end
      end
      CAPTURE: begin
        if (!accum_q) begin
          res_data_d = finalAccumulate;
          res_last_d = last_pass;
          state_d    = EMIT;
        end else begin
          acc_d = acc_sum;
          if (last_pass) begin
            res_data_d = acc_sum;
            res_last_d = 1'b1;
            state_d    = EMIT;
          end else begin
            pass_idx_d = pass_idx_q + 1'b1;
            state_d    = LOAD;
          end
        end
      end
      EMIT: begin
        if (res_ready && res_valid_q) begin
          if (res_last_q) begin
            state_d = FINISH;
          end else begin
            pass_idx_d = pass_idx_q + 1'b1;
            state_d    = LOAD;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    addr_sel_d = (state_d == LOAD && state_q != LOAD) ? addr_nxt : addr_sel_q;
  end

  // Handshake/strobe outputs are registered from the next state so reset drives them all low.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q       <= IDLE;
      passes_q      <= '0;
      pass_idx_q    <= '0;
      base_q        <= '0;
      addr_sel_q    <= '0;
      accum_q       <= 1'b0;
      direct_q      <= 1'b0;
      acc_q         <= '0;
      res_data_q    <= '0;
      res_last_q    <= 1'b0;
      guard_q       <= '0;
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
      op_ready_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mstart_q      <= '0;
    end else begin
      state_q       <= state_d;
      passes_q      <= passes_d;
      pass_idx_q    <= pass_idx_d;
      base_q        <= base_d;
      addr_sel_q    <= addr_sel_d;
      accum_q       <= accum_d;
      direct_q      <= direct_d;
      acc_q         <= acc_d;
      res_data_q    <= res_data_d;
      res_last_q    <= res_last_d;
      guard_q       <= guard_d;
      tmo_q         <= tmo_d;
      timeout_err_q <= timeout_err_d;
      cmd_ready_q   <= (state_d == IDLE);
      op_ready_q    <= (state_d == LOAD);
      res_valid_q   <= (state_d == EMIT);
      busy_q        <= (state_d != IDLE);
      done_q        <= (state_d == FINISH);
      mstart_q      <= (state_d == START) ? '1 : '0;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign op_ready      = op_ready_q;
  assign mStart        = mstart_q;
  assign AddressSelect = addr_sel_q;
  assign direct        = direct_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_last      = res_last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign timeout_err   = timeout_err_q;

`ifdef MATRIX_SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        stall_now;

  assign stall_now = (state_q == LOAD && !op_valid) || (state_q == EMIT && !res_ready);

  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    if (state_q == IDLE && cmd_fire) begin
      perf_busy_d  = '0;
      perf_stall_d = '0;
    end else begin
      if (busy_q && perf_busy_q != '1)     perf_busy_d  = perf_busy_q + 1'b1;
      if (stall_now && perf_stall_q != '1) perf_stall_d = perf_stall_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_busy_cycles  = perf_busy_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_matrix_accel_sequencer.sv
// Directed self-checking bench for matrix_accel_sequencer with a simple accelerator latency model.
module tb_matrix_accel_sequencer;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cmd_valid, cmd_ready;
  logic [7:0]          cmd_passes;
  logic [6:0]          cmd_addr_base;
  logic                cmd_direct, cmd_accumulate;
  logic                op_valid, op_ready;
  logic [8:0]          mStart;
  logic [6:0]          AddressSelect;
  logic                direct;
  logic                finalReady;
  logic signed [31:0]  finalAccumulate;
  logic                res_valid, res_ready;
  logic signed [31:0]  res_data;
  logic                res_last, busy, done, timeout_err;

  int n_chk = 0;
  int n_bad = 0;

  // Accelerator model: after mStart, raise ready `lat` edges later with the next queued value.
  logic [31:0] vals [0:31];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          m_cnt  = 0;
  int          lat    = 3;
  logic        model_rdy;
  logic [31:0] model_data = '0;
  logic        fr_force_en, fr_force_val;
  logic [31:0] force_data;
  int          mstart_cnt = 0;
  int          hs_cnt     = 0;

  assign finalReady      = fr_force_en ? fr_force_val : model_rdy;
  assign finalAccumulate = fr_force_en ? force_data : model_data;

  always #5 clk = ~clk;

  matrix_accel_sequencer #(
    .DATA_WIDTH     (32),
    .KERNEL_SIZE    (3),
    .PASS_W         (8),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .Clk             (clk),
    .Rst             (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_passes      (cmd_passes),
    .cmd_addr_base   (cmd_addr_base),
    .cmd_direct      (cmd_direct),
    .cmd_accumulate  (cmd_accumulate),
    .op_valid        (op_valid),
    .op_ready        (op_ready),
    .mStart          (mStart),
    .AddressSelect   (AddressSelect),
    .direct          (direct),
    .finalReady      (finalReady),
    .finalAccumulate (finalAccumulate),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .res_last        (res_last),
    .busy            (busy),
    .done            (done),
    .timeout_err     (timeout_err)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt     <= 0;
      model_rdy <= 1'b0;
      rd_ptr    <= wr_ptr;
    end else if (mStart == '1) begin
      model_rdy <= 1'b0;
      m_cnt     <= lat;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        model_rdy <= 1'b1;
        if (rd_ptr != wr_ptr) begin
          model_data <= vals[rd_ptr];
          rd_ptr     <= rd_ptr + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && mStart == '1)       mstart_cnt <= mstart_cnt + 1;
    if (rst_n && res_valid && res_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    vals[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic send_cmd(input logic [7:0] p, input logic [6:0] b, input logic d, input logic a);
    int k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 1);
    cmd_valid      = 1'b1;
    cmd_passes     = p;
    cmd_addr_base  = b;
    cmd_direct     = d;
    cmd_accumulate = a;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [31:0] d, input logic l,
                            input logic [6:0] a, input logic dr);
    int k = 0;
    while (!res_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_valid"},  32'(res_valid), 1);
    chk({tag, "_data"},   res_data, d);
    chk({tag, "_last"},   32'(res_last), 32'(l));
    chk({tag, "_addr"},   32'(AddressSelect), 32'(a));
    chk({tag, "_direct"}, 32'(direct), 32'(dr));
    if (res_ready) @(negedge clk);
  endtask

  task automatic wait_mstart(input string tag);
    int k = 0;
    while (mStart == '0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(mStart), 32'h1FF);
  endtask

  task automatic finish_chk(input string tag);
    chk({tag, "_done"},      32'(done), 1);
    chk({tag, "_rdy_in_fin"}, 32'(cmd_ready), 0);
    @(negedge clk);
    chk({tag, "_done_clr"},  32'(done), 0);
    chk({tag, "_idle"},      32'({cmd_ready, busy}), 32'h2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int m0, h0, first_done;
    logic saw_res;

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_passes = '0; cmd_addr_base = '0;
    cmd_direct = 1'b0; cmd_accumulate = 1'b0;
    op_valid = 1'b1; res_ready = 1'b1;
    fr_force_en = 1'b0; fr_force_val = 1'b0; force_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({cmd_ready, op_ready, direct, res_valid, res_last, busy, done, timeout_err}), 0);
    chk("rst_mstart", 32'(mStart), 0);
    chk("rst_addr",   32'(AddressSelect), 0);
    chk("rst_data",   res_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 1);

    // Three independent passes, base 5
    push(32'd10); push(32'd20); push(32'hFFFF_FFF9);
    lat = 3;
    m0 = mstart_cnt;
    send_cmd(8'd3, 7'd5, 1'b0, 1'b0);
    chk("A_busy", 32'(busy), 1);
    expect_res("A0", 32'd10, 1'b0, 7'd5, 1'b0);
    expect_res("A1", 32'd20, 1'b0, 7'd6, 1'b0);
    expect_res("A2", 32'hFFFF_FFF9, 1'b1, 7'd7, 1'b0);
    finish_chk("A");
    chk("A_mstarts", mstart_cnt - m0, 3);

    // Accumulate with two's-complement wrap
    push(32'h7FFF_FFFF); push(32'd1); push(32'd2); push(32'd3);
    lat = 1;
    h0 = hs_cnt;
    send_cmd(8'd4, 7'd10, 1'b1, 1'b1);
    expect_res("B", 32'h8000_0005, 1'b1, 7'd13, 1'b1);
    finish_chk("B");
    chk("B_one_result", hs_cnt - h0, 1);

    // Address wrap 80 -> 0, direct held
    push(32'd1); push(32'd2);
    lat = 2;
    send_cmd(8'd2, 7'd80, 1'b1, 1'b0);
    expect_res("C0", 32'd1, 1'b0, 7'd80, 1'b1);
    expect_res("C1", 32'd2, 1'b1, 7'd0, 1'b1);
    finish_chk("C");

    // Stuck-high finalReady: capture only after the guard window
    fr_force_en = 1'b1; fr_force_val = 1'b1; force_data = 32'h55;
    send_cmd(8'd1, 7'd0, 1'b0, 1'b0);
    wait_mstart("S_mstart");
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("S_no_early_res", 32'(res_valid), 0);
    end
    @(negedge clk);
    chk("S_res_valid", 32'(res_valid), 1);
    chk("S_res_data",  res_data, 32'h55);
    chk("S_res_last",  32'(res_last), 1);
    @(negedge clk);
    finish_chk("S");

    // Stuck-low finalReady: timeout after 64 cycles from START
    fr_force_val = 1'b0;
    m0 = mstart_cnt;
    h0 = hs_cnt;
    send_cmd(8'd3, 7'd20, 1'b0, 1'b0);
    wait_mstart("T_mstart");
    first_done = 0;
    saw_res = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (res_valid) saw_res = 1'b1;
      if (done) begin
        first_done = k;
        break;
      end
    end
    chk("T_done_at",  first_done, 64);
    chk("T_err",      32'(timeout_err), 1);
    chk("T_no_res",   32'(saw_res), 0);
    @(negedge clk);
    chk("T_err_sticky", 32'(timeout_err), 1);
    chk("T_idle",       32'({cmd_ready, busy}), 32'h2);
    chk("T_one_start",  mstart_cnt - m0, 1);
    chk("T_no_hs",      hs_cnt - h0, 0);
    fr_force_en = 1'b0;

    // Result backpressure
    push(32'd42); push(32'd43);
    lat = 3;
    res_ready = 1'b0;
    send_cmd(8'd2, 7'd3, 1'b0, 1'b0);
    chk("BP_err_clr", 32'(timeout_err), 0);
    expect_res("BP0", 32'd42, 1'b0, 7'd3, 1'b0);
    m0 = mstart_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("BP_hold_valid",  32'(res_valid), 1);
      chk("BP_hold_data",   res_data, 32'd42);
      chk("BP_hold_last",   32'(res_last), 0);
      chk("BP_hold_mstart", 32'(mStart), 0);
    end
    chk("BP_no_new_pass", mstart_cnt - m0, 0);
    res_ready = 1'b1;
    @(negedge clk);
    expect_res("BP1", 32'd43, 1'b1, 7'd4, 1'b0);
    finish_chk("BP");

    // Reset in the middle of WAIT
    push(32'd99);
    lat = 20;
    send_cmd(8'd2, 7'd12, 1'b1, 1'b0);
    wait_mstart("R_mstart");
    @(negedge clk);
    @(negedge clk);
    chk("R_pre_addr", 32'(AddressSelect), 12);
    rst_n = 1'b0;
    #1;
    chk("R_ctrl",   32'({cmd_ready, op_ready, direct, res_valid, res_last, busy, done, timeout_err}), 0);
    chk("R_mstart", 32'(mStart), 0);
    chk("R_addr",   32'(AddressSelect), 0);
    chk("R_data",   res_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    h0 = hs_cnt;
    push(32'd77);
    lat = 2;
    send_cmd(8'd1, 7'd9, 1'b0, 1'b0);
    expect_res("R2", 32'd77, 1'b1, 7'd9, 1'b0);
    finish_chk("R2");
    chk("R_one_result", hs_cnt - h0, 1);

    // Zero-pass job
    m0 = mstart_cnt;
    h0 = hs_cnt;
    send_cmd(8'd0, 7'd0, 1'b0, 1'b0);
    chk("Z_res_valid", 32'(res_valid), 0);
    finish_chk("Z");
    chk("Z_no_mstart", mstart_cnt - m0, 0);
    chk("Z_no_result", hs_cnt - h0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
